// File: rtl/compare_state_monitor.sv
// compare_state_monitor: debounces the one-hot aeqb/agtb/altb flags of a
// magnitude comparator into a confirmed relation state, counts confirmed
// entries into ABOVE/BELOW and flags illegal (non-one-hot) samples.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid            flags valid this cycle
//   aeqb, agtb, altb    comparator flags (expected one-hot)
//   clear               synchronous clear of state, counters and error
//   state[1:0]          confirmed relation: 00 IDLE, 01 EQUAL, 10 ABOVE, 11 BELOW
//   state_change        one-cycle pulse when state commits a new value
//   gt_count, lt_count  saturating counts of confirmed ABOVE/BELOW entries
//   flag_err            sticky illegal-sample indicator
module compare_state_monitor #(
    parameter int unsigned CONFIRM = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             aeqb,
    input  logic             agtb,
    input  logic             altb,
    input  logic             clear,
    output logic [1:0]       state,
    output logic             state_change,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic             flag_err
);

    // Run counter only needs to reach CONFIRM (at most 15).
    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EQUAL = 2'b01,
        ST_ABOVE = 2'b10,
        ST_BELOW = 2'b11
    } rel_e;

    rel_e             state_q, state_d;
    rel_e             cand_q, cand_d;
    rel_e             sample_rel_c;
    logic             sample_legal_c;
    logic [RUN_W-1:0] run_q, run_d, run_upd_c;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] gt_q, gt_d, lt_q, lt_d;
    logic             err_q, err_d;

    // Decode the flag triple into a relation; anything not one-hot is illegal.
    always_comb begin
        sample_legal_c = 1'b1;
        sample_rel_c   = ST_IDLE;
        case ({aeqb, agtb, altb})
            3'b100:  sample_rel_c = ST_EQUAL;
            3'b010:  sample_rel_c = ST_ABOVE;
            3'b001:  sample_rel_c = ST_BELOW;
            default: sample_legal_c = 1'b0;
        endcase
    end

    // Next-state: candidate tracking, confirmation and commit.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        run_d     = run_q;
        run_upd_c = '0;
        chg_d     = 1'b0;
        gt_d      = gt_q;
        lt_d      = lt_q;
        err_d     = err_q;

        if (clear) begin
            state_d = ST_IDLE;
            cand_d  = ST_IDLE;
            run_d   = '0;
            gt_d    = '0;
            lt_d    = '0;
            err_d   = 1'b0;
        end else if (in_valid) begin
            if (!sample_legal_c) begin
                err_d = 1'b1;
                run_d = '0;
            end else if (sample_rel_c == state_q) begin
                // Current state re-confirmed: any pending candidate is dropped.
                run_d = '0;
            end else begin
                if (sample_rel_c == cand_q) begin
                    run_upd_c = run_q + RUN_W'(1);
                end else begin
                    cand_d    = sample_rel_c;
                    run_upd_c = RUN_W'(1);
                end

                if (run_upd_c == RUN_W'(CONFIRM)) begin
                    state_d = sample_rel_c;
                    run_d   = '0;
                    chg_d   = 1'b1;
                    if (sample_rel_c == ST_ABOVE && gt_q != {CNT_W{1'b1}}) begin
                        gt_d = gt_q + CNT_W'(1);
                    end
                    if (sample_rel_c == ST_BELOW && lt_q != {CNT_W{1'b1}}) begin
                        lt_d = lt_q + CNT_W'(1);
                    end
                end else begin
                    run_d = run_upd_c;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cand_q  <= ST_IDLE;
            run_q   <= '0;
            chg_q   <= 1'b0;
            gt_q    <= '0;
            lt_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
            chg_q   <= chg_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
        end
    end

    assign state        = state_q;
    assign state_change = chg_q;
    assign gt_count     = gt_q;
    assign lt_count     = lt_q;
    assign flag_err     = err_q;

endmodule

// File: tb/tb_compare_state_monitor.sv
// Testbench for compare_state_monitor: two instances (CONFIRM=3/CNT_W=8 and
// CONFIRM=1/CNT_W=2) share stimulus and are compared against a behavioural
// model after every clock edge, plus directed checks from the test plan.
module tb_compare_state_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic aeqb = 1'b0;
    logic agtb = 1'b0;
    logic altb = 1'b0;
    logic clear = 1'b0;

    logic [1:0] st_a, st_b;
    logic       chg_a, chg_b;
    logic [7:0] gt_a, lt_a;
    logic [1:0] gt_b, lt_b;
    logic       err_a, err_b;

    int vectors = 0;
    int miscompares = 0;

    // Model state per instance: 0 = CONFIRM 3 / CNT_W 8, 1 = CONFIRM 1 / CNT_W 2.
    int conf[2] = '{3, 1};
    int cmax[2] = '{255, 3};
    int m_st[2], m_cand[2], m_run[2], m_gt[2], m_lt[2], m_err[2], m_chg[2];

    always #5 clk = ~clk;

    compare_state_monitor u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .aeqb(aeqb), .agtb(agtb), .altb(altb), .clear(clear),
        .state(st_a), .state_change(chg_a),
        .gt_count(gt_a), .lt_count(lt_a), .flag_err(err_a)
    );

    compare_state_monitor #(.CONFIRM(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .aeqb(aeqb), .agtb(agtb), .altb(altb), .clear(clear),
        .state(st_b), .state_change(chg_b),
        .gt_count(gt_b), .lt_count(lt_b), .flag_err(err_b)
    );

    task automatic check(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cand[i] = 0; m_run[i] = 0;
            m_gt[i] = 0; m_lt[i] = 0; m_err[i] = 0; m_chg[i] = 0;
        end
    endtask

    // One clock edge of the relation filter, straight from the behaviour rules.
    task automatic model_step(input bit v, input bit e, input bit g, input bit l, input bit c);
        int ones;
        int rel;
        ones = int'(e) + int'(g) + int'(l);
        rel  = e ? 1 : (g ? 2 : 3);
        for (int i = 0; i < 2; i++) begin
            m_chg[i] = 0;
            if (c) begin
                m_st[i] = 0; m_cand[i] = 0; m_run[i] = 0;
                m_gt[i] = 0; m_lt[i] = 0; m_err[i] = 0;
            end else if (v) begin
                if (ones != 1) begin
                    m_err[i] = 1;
                    m_run[i] = 0;
                end else if (rel == m_st[i]) begin
                    m_run[i] = 0;
                end else begin
                    if (rel == m_cand[i]) m_run[i]++;
                    else begin m_cand[i] = rel; m_run[i] = 1; end
                    if (m_run[i] == conf[i]) begin
                        m_st[i]  = rel;
                        m_run[i] = 0;
                        m_chg[i] = 1;
                        if (rel == 2 && m_gt[i] < cmax[i]) m_gt[i]++;
                        if (rel == 3 && m_lt[i] < cmax[i]) m_lt[i]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check("a_state", int'(st_a),  m_st[0]);
        check("a_chg",   int'(chg_a), m_chg[0]);
        check("a_gt",    int'(gt_a),  m_gt[0]);
        check("a_lt",    int'(lt_a),  m_lt[0]);
        check("a_err",   int'(err_a), m_err[0]);
        check("b_state", int'(st_b),  m_st[1]);
        check("b_chg",   int'(chg_b), m_chg[1]);
        check("b_gt",    int'(gt_b),  m_gt[1]);
        check("b_lt",    int'(lt_b),  m_lt[1]);
        check("b_err",   int'(err_b), m_err[1]);
    endtask

    // Drive one cycle of inputs, step the model at the edge, compare after it.
    task automatic apply(input bit v, input bit e, input bit g, input bit l, input bit c);
        in_valid = v; aeqb = e; agtb = g; altb = l; clear = c;
        @(posedge clk);
        model_step(v, e, g, l, c);
        #1;
        check_all();
    endtask

    task automatic rel_n(input int rel, input int n);
        for (int k = 0; k < n; k++)
            apply(1'b1, rel == 1, rel == 2, rel == 3, 1'b0);
    endtask

    initial begin
        bit v, e, g, l, c;
        int cur;

        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Three ABOVE samples commit ABOVE on the third edge.
        rel_n(2, 2);
        check("tp1_pre_state", int'(st_a), 0);
        rel_n(2, 1);
        check("tp1_state", int'(st_a), 2);
        check("tp1_chg", int'(chg_a), 1);
        check("tp1_gt", int'(gt_a), 1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tp1_chg_drop", int'(chg_a), 0);

        // EQUAL interrupts the BELOW run; BELOW commits only after 3 fresh samples.
        rel_n(3, 2);
        rel_n(1, 1);
        rel_n(3, 2);
        check("tp2_hold", int'(st_a), 2);
        rel_n(3, 1);
        check("tp2_state", int'(st_a), 3);
        check("tp2_lt", int'(lt_a), 1);

        // Invalid gap does not break an ABOVE run.
        rel_n(2, 2);
        for (int k = 0; k < 4; k++) apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rel_n(2, 1);
        check("tp3_state", int'(st_a), 2);
        check("tp3_gt", int'(gt_a), 2);

        // Illegal samples set the sticky error; clear wipes everything.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tp4_err", int'(err_a), 1);
        check("tp4_state", int'(st_a), 2);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("tp4_clr_err", int'(err_a), 0);
        check("tp4_clr_gt", int'(gt_a), 0);

        // CONFIRM=1 / CNT_W=2 instance: counters saturate at 3.
        for (int k = 0; k < 10; k++) rel_n((k % 2 == 0) ? 2 : 3, 1);
        check("tp5_gt_sat", int'(gt_b), 3);
        check("tp5_lt_sat", int'(lt_b), 3);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Clear on the 3rd matching sample blocks the commit.
        rel_n(2, 2);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("tp6_clr_state", int'(st_a), 0);
        check("tp6_clr_chg", int'(chg_a), 0);

        // Asynchronous reset mid-run.
        rel_n(3, 5);
        rel_n(2, 2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized stimulus with sticky relations so runs complete.
        cur = 2;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) cur = $urandom_range(1, 3);
            v = ($urandom_range(0, 9) < 8);
            e = (cur == 1); g = (cur == 2); l = (cur == 3);
            if ($urandom_range(0, 29) == 0) begin
                e = 1'($urandom); g = 1'($urandom); l = 1'($urandom);
            end
            c = ($urandom_range(0, 59) == 0);
            apply(v, e, g, l, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
